l2_backing_memory: RTL and testbench

//  Main-memory responder for the L2 cache memory port: the target end of the mem_* handshake the L2 initiates.

---
 rtl/l2_backing_memory_if.sv | 27 ++
 rtl/l2_backing_memory.sv | 162 ++++++++++++++++
 tb/tb_l2_backing_memory.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/l2_backing_memory_if.sv
// l2_backing_memory_if: L2-to-main-memory block port.
//   master : the L2 cache side (drives address, write data, read/write requests)
//   slave  : the backing memory side (drives read data and the ready/hit pulses)
// Signals keep the cache-side net names so both ends connect by name.
interface l2_backing_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_SIZE = 16
);
  logic [ADDR_WIDTH-1:0]            mem_addr;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out;
  logic                             mem_read;
  logic                             mem_write;
  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_in;
  logic                             mem_ready;
  logic                             mem_hit;

  modport master (
    output mem_addr, mem_data_out, mem_read, mem_write,
    input  mem_data_in, mem_ready, mem_hit
  );

  modport slave (
    input  mem_addr, mem_data_out, mem_read, mem_write,
    output mem_data_in, mem_ready, mem_hit
  );
endinterface

// File: rtl/l2_backing_memory.sv
// l2_backing_memory: fixed-latency main-memory responder for the L2 memory port.
// Stores DEPTH blocks of BLOCK_SIZE words; serves block reads (fills) and block
// writes (write-backs). The most recently completed block stays "open" and is
// served with HIT_LATENCY, signalled on mem_hit instead of mem_ready.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset (storage contents are kept)
//   mem  - slave side of l2_backing_memory_if (addr/data/read/write in,
//          data_in/ready/hit out)
module l2_backing_memory #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 32,
  parameter int BLOCK_SIZE    = 16,
  parameter int DEPTH         = 256,
  parameter int READ_LATENCY  = 10,
  parameter int WRITE_LATENCY = 10,
  parameter int HIT_LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  l2_backing_memory_if.slave    mem
);
  localparam int BLK_W   = BLOCK_SIZE * DATA_WIDTH;
  localparam int OFF     = $clog2(BLOCK_SIZE);
  localparam int IDX_W   = $clog2(DEPTH);
  localparam int MAX_RW  = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int MAX_LAT = (MAX_RW > HIT_LATENCY) ? MAX_RW : HIT_LATENCY;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  // Counter is loaded with L-1 so the response is registered at edge L.
  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WRITE_LATENCY - 1);
  localparam logic [CNT_W-1:0] HIT_CNT = CNT_W'(HIT_LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND, RECOVER} state_t;

  // Power-up image: word w of block b holds (b << 8) | w.
  function automatic logic [BLK_W-1:0] init_block(input int b);
    logic [BLK_W-1:0] v;
    v = '0;
    for (int w = 0; w < BLOCK_SIZE; w++) begin
      v[w*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'((b << 8) | w);
    end
    return v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_q, wr_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BLK_W-1:0]   wdata_q, wdata_d;
  logic               open_acc_q, open_acc_d;
  logic [IDX_W-1:0]   open_blk_q, open_blk_d;
  logic               open_valid_q, open_valid_d;
  logic               ready_q, ready_d;
  logic               hit_q, hit_d;
  logic [BLK_W-1:0]   data_in_q, data_in_d;

  logic [IDX_W-1:0]   req_idx;
  logic               commit;
  logic [BLK_W-1:0]   blk_rd [DEPTH];
  logic               unused_addr_bits;

  // Offset bits and bits above the index are dropped, so upper addresses alias.
  assign req_idx          = mem.mem_addr[OFF +: IDX_W];
  assign unused_addr_bits = ^mem.mem_addr;

  // A write lands on the edge leaving RESPOND; a reset on that edge cancels it.
  assign commit = (state_q == RESPOND) && wr_q && !rst;

  // ---- storage array: one block register per index, not reset ----
  for (genvar b = 0; b < DEPTH; b++) begin : g_blk
    logic [BLK_W-1:0] blk_q = init_block(b);
    logic [BLK_W-1:0] blk_d;

    always_comb begin
      blk_d = blk_q;
      if (commit && (idx_q == IDX_W'(b))) blk_d = wdata_q;
    end

    always_ff @(posedge clk) begin
      blk_q <= blk_d;
    end

    assign blk_rd[b] = blk_q;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    idx_d        = idx_q;
    wdata_d      = wdata_q;
    open_acc_d   = open_acc_q;
    open_blk_d   = open_blk_q;
    open_valid_d = open_valid_q;
    ready_d      = 1'b0;
    hit_d        = 1'b0;
    data_in_d    = data_in_q;
    case (state_q)
      IDLE: begin
        // Write has priority; a read still held is picked up after RECOVER.
        if (mem.mem_write || mem.mem_read) begin
          wr_d       = mem.mem_write;
          idx_d      = req_idx;
          wdata_d    = mem.mem_data_out;
          open_acc_d = open_valid_q && (req_idx == open_blk_q);
          if (open_acc_d)         cnt_d = HIT_CNT;
          else if (mem.mem_write) cnt_d = WR_CNT;
          else                    cnt_d = RD_CNT;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          state_d = RESPOND;
          ready_d = !open_acc_q;
          hit_d   = open_acc_q;
          // Read data is held until the next read response.
          if (!wr_q) data_in_d = blk_rd[idx_q];
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESPOND: begin
        open_blk_d   = idx_q;
        open_valid_d = 1'b1;
        state_d      = RECOVER;
      end
      RECOVER: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- control registers reset; latched request datapath is not ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      open_valid_q <= 1'b0;
      ready_q      <= 1'b0;
      hit_q        <= 1'b0;
      data_in_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      open_valid_q <= open_valid_d;
      ready_q      <= ready_d;
      hit_q        <= hit_d;
      data_in_q    <= data_in_d;
    end
    wr_q       <= wr_d;
    idx_q      <= idx_d;
    wdata_q    <= wdata_d;
    open_acc_q <= open_acc_d;
    open_blk_q <= open_blk_d;
  end

  assign mem.mem_ready   = ready_q;
  assign mem.mem_hit     = hit_q;
  assign mem.mem_data_in = data_in_q;
endmodule

// File: tb/tb_l2_backing_memory.sv
module tb_l2_backing_memory;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int BS    = 16;
  localparam int DEPTH = 256;
  localparam int BW    = DW * BS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_backing_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS)) mem_if ();

  l2_backing_memory #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_SIZE(BS), .DEPTH(DEPTH),
    .READ_LATENCY(10), .WRITE_LATENCY(10), .HIT_LATENCY(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mem (mem_if.slave)
  );

  typedef struct {
    logic             hit;
    logic             rd;
    logic [BW-1:0]    data;
    int               lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   t0  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] blk_pat(input logic [31:0] base);
    logic [BW-1:0] v;
    for (int w = 0; w < BS; w++) v[w*DW +: DW] = base + 32'(w);
    return v;
  endfunction

  task automatic expect_resp(input logic hit, input logic rd, input logic [BW-1:0] d, input int lat);
    exp_t e;
    e.hit = hit; e.rd = rd; e.data = d; e.lat = lat;
    sb_q.push_back(e);
  endtask

  // Request goes up after a negedge; the next posedge is edge 0.
  task automatic drive(input logic [AW-1:0] a, input logic rd, input logic wr, input logic [BW-1:0] d);
    @(negedge clk);
    mem_if.mem_addr     = a;
    mem_if.mem_data_out = d;
    mem_if.mem_read     = rd;
    mem_if.mem_write    = wr;
    t0 = cyc + 1;
  endtask

  task automatic collect(input int n);
    for (int k = 0; k < n; k++) begin
      int   waited;
      exp_t e;
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!(mem_if.mem_ready || mem_if.mem_hit) && waited < 60);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        if (!(mem_if.mem_ready || mem_if.mem_hit)) begin
          check("timeout", BW'(waited), BW'(e.lat));
        end else begin
          check("kind{ready,hit}", BW'({mem_if.mem_ready, mem_if.mem_hit}), BW'({~e.hit, e.hit}));
          check("latency", BW'(cyc - t0), BW'(e.lat));
          if (e.rd) check("rdata", mem_if.mem_data_in, e.data);
        end
      end
      mem_if.mem_write = 1'b0;
      if (k == n - 1) mem_if.mem_read = 1'b0;
      @(negedge clk);
      check("pulse_width", BW'({mem_if.mem_ready, mem_if.mem_hit}), '0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] model [int];
    logic          mv;
    int            mo;
    int            pulses;

    rst = 1'b1;
    mem_if.mem_addr     = '0;
    mem_if.mem_data_out = '0;
    mem_if.mem_read     = 1'b0;
    mem_if.mem_write    = 1'b0;

    // Reset held three cycles with requests low.
    repeat (3) @(negedge clk);
    check("rst_ready", BW'(mem_if.mem_ready), '0);
    check("rst_hit", BW'(mem_if.mem_hit), '0);
    check("rst_data_in", mem_if.mem_data_in, '0);
    rst = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (mem_if.mem_ready || mem_if.mem_hit) pulses++;
    end
    check("idle_no_pulse", BW'(pulses), '0);
    check("idle_data_in", mem_if.mem_data_in, '0);

    // Cold read, then repeat read from the open block.
    expect_resp(1'b0, 1'b1, blk_pat(32'h1400), 10);
    drive(32'h0000_0140, 1'b1, 1'b0, '0);
    collect(1);
    expect_resp(1'b1, 1'b1, blk_pat(32'h1400), 2);
    drive(32'h0000_0140, 1'b1, 1'b0, '0);
    collect(1);

    // Write to the open block, evict it, read it back, then an aliased address.
    expect_resp(1'b1, 1'b0, '0, 2);
    drive(32'h0000_0140, 1'b0, 1'b1, blk_pat(32'hA5A5_0000));
    collect(1);
    expect_resp(1'b0, 1'b1, blk_pat(32'h2000), 10);
    drive(32'h0000_0200, 1'b1, 1'b0, '0);
    collect(1);
    expect_resp(1'b0, 1'b1, blk_pat(32'hA5A5_0000), 10);
    drive(32'h0000_0140, 1'b1, 1'b0, '0);
    collect(1);
    expect_resp(1'b1, 1'b1, blk_pat(32'hA5A5_0000), 2);
    drive(32'h0000_1140, 1'b1, 1'b0, '0);
    collect(1);

    // Read and write together: write (closed) first, then the read from the
    // now-open block, sampled at edge 13 and answered 2 edges later.
    expect_resp(1'b0, 1'b0, '0, 10);
    expect_resp(1'b1, 1'b1, blk_pat(32'hA5A5_3000), 15);
    drive(32'h0000_0300, 1'b1, 1'b1, blk_pat(32'hA5A5_3000));
    collect(2);

    // Reset in the middle of a write: no pulse, nothing committed.
    drive(32'h0000_0400, 1'b0, 1'b1, blk_pat(32'hDEAD_0000));
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_if.mem_write = 1'b0;
    pulses = 0;
    repeat (15) begin
      @(negedge clk);
      if (mem_if.mem_ready || mem_if.mem_hit) pulses++;
    end
    check("abort_no_pulse", BW'(pulses), '0);
    expect_resp(1'b0, 1'b1, blk_pat(32'h4000), 10);
    drive(32'h0000_0400, 1'b1, 1'b0, '0);
    collect(1);
    expect_resp(1'b0, 1'b1, blk_pat(32'hA5A5_3000), 10);
    drive(32'h0000_0300, 1'b1, 1'b0, '0);
    collect(1);

    // Random mix on fresh blocks after a reset, against a small reference model.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mv = 1'b0;
    mo = 0;
    for (int i = 0; i < 10; i++) begin
      int            idx;
      logic          wr;
      logic          hit;
      logic [AW-1:0] a;
      logic [BW-1:0] d;
      idx = 'h50 + int'($urandom_range(0, 2));
      wr  = 1'($urandom_range(0, 1));
      a   = ($urandom() & 32'hFFFF_F000) | 32'(idx << 4) | 32'($urandom_range(0, 15));
      hit = mv && (idx == mo);
      if (wr) begin
        d = blk_pat($urandom() & 32'hFFFF_0000);
        model[idx] = d;
        expect_resp(hit, 1'b0, '0, hit ? 2 : 10);
      end else begin
        d = '0;
        expect_resp(hit, 1'b1, model.exists(idx) ? model[idx] : blk_pat(32'(idx << 8)), hit ? 2 : 10);
      end
      mv = 1'b1;
      mo = idx;
      drive(a, ~wr, wr, d);
      collect(1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
